// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the RV32M multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            stall_req;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, flush, op, rs1_data, rs2_data, rd_in,
        input  stall_req, done, result, rd_out
    );

    modport slave (
        input  start, flush, op, rs1_data, rs2_data, rd_in,
        output stall_req, done, result, rd_out
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a one-cycle product.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic             clk,
    input logic             rst,
    ex_muldiv_unit_if.slave bus
);
    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state, next_state;
    logic [2:0]      op_q;
    logic [4:0]      rd_q, rd_out_q;
    logic [XLEN-1:0] a_q, b_q, result_q;
    logic [W2-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic            neg_q, rem_neg_q;

    logic            accept, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            last, mul_last;
    logic [W2-1:0]   mul_next, mul_fin;
    logic [XLEN-1:0] mul_res;
    logic [XLEN:0]   partial;
    logic            ge;
    logic [XLEN-1:0] new_rem, quo_fin, rem_fin, div_res;
    logic [W2-1:0]   div_next;
`ifndef MULDIV_FAST_MUL_EN
    logic [XLEN:0]   mul_sum;
`endif

    always_comb begin
        accept   = (state == IDLE) && bus.start && !bus.flush && !rst;
        a_signed = !bus.op[0] || (bus.op == 3'd1);
        b_signed = bus.op[2] ? !bus.op[0] : !bus.op[1];
        a_neg    = a_signed && bus.rs1_data[XLEN-1];
        b_neg    = b_signed && bus.rs2_data[XLEN-1];
        a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
        b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;

        div_zero = (bus.rs2_data == '0);
        div_ovf  = !bus.op[0] && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.rs2_data == '1);
        special  = bus.op[2] && (div_zero || div_ovf);
        if (div_zero)
            special_res = bus.op[1] ? bus.rs1_data : '1;
        else
            special_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};

        last = (cnt == CNT_W'(XLEN - 1));
`ifdef MULDIV_FAST_MUL_EN
        mul_last = 1'b1;
        mul_next = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
`else
        // Right-shifting accumulator: product bits settle into the low half.
        mul_last = last;
        mul_sum  = {1'b0, acc[W2-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
`endif
        mul_fin = neg_q ? -mul_next : mul_next;
        mul_res = (op_q == 3'd0) ? mul_fin[XLEN-1:0] : mul_fin[W2-1:XLEN];

        // Upper half holds the partial remainder, lower half collects quotient bits.
        partial  = {acc[W2-1:XLEN], a_q[XLEN-1]};
        ge       = (partial >= {1'b0, b_q});
        new_rem  = ge ? XLEN'(partial - {1'b0, b_q}) : partial[XLEN-1:0];
        div_next = {new_rem, acc[XLEN-2:0], ge};
        quo_fin  = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        rem_fin  = rem_neg_q ? -new_rem : new_rem;
        div_res  = op_q[1] ? rem_fin : quo_fin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state    = state;
        bus.stall_req = 1'b0;
        bus.done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    bus.stall_req = 1'b1;
                    if (!bus.op[2])
                        next_state = MUL;
                    else
                        next_state = special ? DONE : DIV;
                end
            end
            MUL: begin
                bus.stall_req = 1'b1;
                if (bus.flush)
                    next_state = IDLE;
                else if (mul_last)
                    next_state = DONE;
            end
            DIV: begin
                bus.stall_req = 1'b1;
                if (bus.flush)
                    next_state = IDLE;
                else if (last)
                    next_state = DONE;
            end
            DONE: begin
                bus.done   = !bus.flush;
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            rd_q      <= '0;
            rd_out_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= bus.op;
                        rd_q      <= bus.rd_in;
                        a_q       <= a_mag;
                        b_q       <= b_mag;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        acc       <= '0;
                        cnt       <= '0;
                        if (special) begin
                            result_q <= special_res;
                            rd_out_q <= bus.rd_in;
                        end
                    end
                end
                MUL: begin
                    if (!bus.flush) begin
                        acc <= mul_next;
                        b_q <= b_q >> 1;
                        cnt <= cnt + CNT_W'(1);
                        if (mul_last) begin
                            result_q <= mul_res;
                            rd_out_q <= rd_q;
                        end
                    end
                end
                DIV: begin
                    if (!bus.flush) begin
                        acc <= div_next;
                        a_q <= a_q << 1;
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            result_q <= div_res;
                            rd_out_q <= rd_q;
                        end
                    end
                end
                DONE: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage operands, funct3 and rd for M-extension instructions.
- Raises a stall request while computing. Presents the result and rd for one cycle so the EX/MEM register captures it when the pipeline advances.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  EX holds a valid M-extension instruction.
- flush  input  1  kill in-flight operation (branch/jump redirect).
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  input  XLEN  dividend / multiplicand (already forwarded).
- rs2_data  input  XLEN  divisor / multiplier (already forwarded).
- rd_in  input  5  destination register of the EX instruction.
- stall_req  output  1  hold IF/ID/EX stages.
- done  output  1  result valid, single-cycle pulse.
- result  output  XLEN  selected product half, quotient or remainder.
- rd_out  output  5  rd latched at accept.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all internal registers 0, done=0, result=0, rd_out=0, stall_req=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and flush=0 -> latch op and rd_in.
  - Convert operands to magnitudes per op signedness and record result sign.
  - Zero the 2*XLEN accumulator; counter=0.
  - Go to MUL (op<4) or DIV (op>=4).
- Special-case divides, taken from IDLE straight to DONE:
  - Divisor 0: quotient = all-ones; remainder = rs1_data unmodified.
  - Signed overflow (rs1 = 0x8000_0000, rs2 = 0xFFFF_FFFF, DIV/REM): quotient = 0x8000_0000, remainder = 0.
- MUL: radix-2 shift-add, one multiplier bit per cycle, XLEN cycles. After the last iteration, apply sign correction (two's complement of the 2*XLEN product when signs differ) and go to DONE.
- DIV: restoring division, one quotient bit per cycle, XLEN cycles.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
  - Go to DONE.
- Result select:
  - MUL -> product[XLEN-1:0].
  - MULH / MULHSU / MULHU -> product[2*XLEN-1:XLEN].
  - DIV(U) -> quotient.
  - REM(U) -> remainder.
- DONE: done=1 for exactly one cycle. result and rd_out valid; they are registered and held until the next accept. Always returns to IDLE. start is ignored in DONE, because the same instruction is still present.
- stall_req (combinational) = (state==MUL or DIV) or (state==IDLE and start and !flush). It is 0 in DONE, so the pipeline advances on that edge.
- Latency:
  - Normal op: accept edge -> XLEN iteration cycles -> DONE. done is high in cycle XLEN+1 after accept (33 for XLEN=32).
  - Special-case divide: done in cycle 1.
- flush: in MUL/DIV/DONE -> next state IDLE, done=0, no result update. In IDLE, flush blocks acceptance. flush and start in the same IDLE cycle -> not accepted.
- Operand changes after accept have no effect; operands are latched.
- Counter saturation is not possible: the transition occurs at counter==XLEN-1.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: MUL-class ops compute a single-cycle 2*XLEN signed/unsigned product from the latched operands. The MUL state lasts 1 cycle; done arrives in cycle 2. Divide is unchanged.
- Not defined: iterative shift-add multiply as above. Required for small FPGA fit.

Test Plan:
- MUL 7 x -3 (op=0): accept -> stall_req high 33 cycles -> done in cycle 33, result=0xFFFF_FFEB, rd_out=rd_in.
- MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> result 0xFFFF_FFFE. MULH same operands -> 0x0000_0000. MULHSU -> 0xFFFF_FFFF.
- DIV -7/2 -> 0xFFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFF_FFFF with done in cycle 1. REM 5/0 -> 5. DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM of the same -> 0.
- Flush at cycle 10 of a DIV -> state IDLE next cycle, no done pulse, result keeps its previous value. A new start 2 cycles later completes correctly.
- Assert rst mid-MUL (cycle 15) -> outputs zero immediately (asynchronous), stall_req=0. Repeat the MUL vector with MULDIV_FAST_MUL_EN defined -> done in cycle 2 with the same result.
